// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU results through to writeback
// or runs a load/store over the dmem request/grant/response handshake.
module mem_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [31:0]           alu_res,
    input  logic [31:0]           rs2_data,
    input  logic [4:0]            rd_addr,
    input  logic                  reg_write,
    input  logic [1:0]            mem_op,
    input  logic [1:0]            mem_size,
    input  logic                  mem_unsigned,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [31:0]           dmem_rdata,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic                  wb_reg_write,
    output logic                  wb_misalign
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;

    state_t      state;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        rw_q;
    logic [4:0]  rd_q;

    logic        xfer;
    logic        is_ld;
    logic        is_st;
    logic        misal;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [15:0] ld_lane;
    logic [31:0] ld_data;

    assign ex_ready = (state == IDLE);
    assign xfer     = ex_valid && ex_ready;
    assign is_ld    = (mem_op == OP_LOAD);
    assign is_st    = (mem_op == OP_STORE);

    always_comb begin
        st_wdata = rs2_data;
        st_be    = 4'b1111;
        misal    = |alu_res[1:0];
        unique case (1'b1)
            mem_size == SZ_BYTE: begin
                st_wdata = {4{rs2_data[7:0]}};
                st_be    = 4'b0001 << alu_res[1:0];
                misal    = 1'b0;
            end
            mem_size == SZ_HALF: begin
                st_wdata = {2{rs2_data[15:0]}};
                st_be    = 4'b0011 << alu_res[1:0];
                misal    = alu_res[0];
            end
            default: ;
        endcase
    end

    // Only the low half-word of the shifted lane is ever needed.
    assign ld_lane = 16'(dmem_rdata >> {off_q, 3'b000});

    always_comb begin
        ld_data = dmem_rdata;
        unique case (1'b1)
            size_q == SZ_BYTE:
                ld_data = {{24{~uns_q & ld_lane[7]}}, ld_lane[7:0]};
            size_q == SZ_HALF:
                ld_data = {{16{~uns_q & ld_lane[15]}}, ld_lane};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            rw_q         <= 1'b0;
            rd_q         <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_reg_write <= 1'b0;
            wb_misalign  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (xfer && !(is_ld || is_st)) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= alu_res;
                        wb_rd        <= rd_addr;
                        wb_reg_write <= reg_write;
                        wb_misalign  <= 1'b0;
                    end else if (xfer && misal) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= alu_res;
                        wb_rd        <= rd_addr;
                        wb_reg_write <= 1'b0;
                        wb_misalign  <= 1'b1;
                    end else if (xfer) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_st;
                        dmem_addr  <= {alu_res[ADDR_WIDTH-1:2], 2'b00};
                        dmem_wdata <= st_wdata;
                        dmem_be    <= is_st ? st_be : 4'b0000;
                        off_q      <= alu_res[1:0];
                        size_q     <= mem_size;
                        uns_q      <= mem_unsigned;
                        rw_q       <= reg_write;
                        rd_q       <= rd_addr;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (dmem_we) begin
                            wb_valid     <= 1'b1;
                            wb_rd        <= rd_q;
                            wb_reg_write <= 1'b0;
                            wb_misalign  <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= ld_data;
                        wb_rd        <= rd_q;
                        wb_reg_write <= rw_q;
                        wb_misalign  <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a reference model queues expected
// memory requests and writebacks; a responder and a monitor check them.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] alu_res = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_addr = '0;
    logic        reg_write = 1'b0;
    logic [1:0]  mem_op = '0;
    logic [1:0]  mem_size = '0;
    logic        mem_unsigned = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_reg_write;
    logic        wb_misalign;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_res(alu_res), .rs2_data(rs2_data),
        .rd_addr(rd_addr), .reg_write(reg_write),
        .mem_op(mem_op), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_reg_write(wb_reg_write),
        .wb_misalign(wb_misalign)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rw;
        logic        mis;
        bit          chk_rd;
        bit          chk_data;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          gdly;
        int          rdly;
    } mem_exp_t;

    wb_exp_t  wbq[$];
    mem_exp_t memq[$];
    int       wb_cycs[$];
    int       n_chk = 0;
    int       n_fail = 0;
    int       cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event occurred, required none", nm);
    endtask

    // Reference model: derives expectations from access size and offset.
    task automatic issue(input logic [1:0] op, input logic [1:0] sz,
                         input logic uns, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic [31:0] rdata,
                         input int gd, input int rdl);
        wb_exp_t  w;
        mem_exp_t m;
        int       nb;
        int       off;
        longint   v;
        int       waitc;
        bit       acc;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(alu % 4);
        w.rd = rd; w.data = alu; w.rw = rw; w.mis = 1'b0;
        w.chk_rd = 1'b1; w.chk_data = 1'b1;
        if (op == 2'd1 || op == 2'd2) begin
            if ((alu % nb) != 0) begin
                w.rw = 1'b0; w.mis = 1'b1; w.chk_rd = 1'b0;
            end else begin
                m.we = (op == 2'd2);
                m.addr = alu - 32'(off);
                m.be = 4'(((1 << nb) - 1) << off);
                m.wdata = (nb == 1) ? rs2[7:0] * 32'h0101_0101 :
                          (nb == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
                m.rdata = rdata; m.gdly = gd; m.rdly = rdl;
                memq.push_back(m);
                if (m.we) begin
                    w.rw = 1'b0; w.chk_rd = 1'b0; w.chk_data = 1'b0;
                end else if (nb == 4) begin
                    w.data = rdata;
                end else begin
                    v = longint'(rdata / (32'd1 << (8 * off)));
                    v = v % (64'sd1 << (8 * nb));
                    if (!uns && v >= (64'sd1 << (8 * nb - 1)))
                        v = v - (64'sd1 << (8 * nb));
                    w.data = 32'(v);
                end
            end
        end
        wbq.push_back(w);
        ex_valid = 1'b1; mem_op = op; mem_size = sz; mem_unsigned = uns;
        alu_res = alu; rs2_data = rs2; rd_addr = rd; reg_write = rw;
        waitc = 0; acc = 1'b0;
        while (!acc && waitc < 60) begin
            @(negedge clk);
            acc = ex_ready;
            @(posedge clk);
            waitc++;
        end
        #1 ex_valid = 1'b0;
        if (!acc) fail("ex_ready_timeout");
    endtask

    initial begin : monitor
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && wb_valid) begin
                wb_cycs.push_back(cyc);
                if (wbq.size() == 0) begin
                    fail("wb_unexpected");
                end else begin
                    e = wbq.pop_front();
                    chk("wb_misalign", 32'(wb_misalign), 32'(e.mis));
                    chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                    if (e.chk_rd) chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    if (e.chk_data) chk("wb_data", wb_data, e.data);
                end
            end
        end
    end

    initial begin : responder
        mem_exp_t cur;
        int       ph;
        int       cnt;
        ph = 0; cnt = 0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata = $urandom;
            if (!rst_n) begin
                ph = 0;
            end else if (ph == 0) begin
                if (dmem_req) begin
                    if (memq.size() == 0) begin
                        fail("dmem_req_unexpected");
                    end else begin
                        cur = memq.pop_front();
                        cnt = cur.gdly;
                        ph = 1;
                    end
                end
            end else if (ph == 2) begin
                chk("dmem_req_after_gnt", 32'(dmem_req), 32'd0);
                if (cnt == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata = cur.rdata;
                    ph = 0;
                end else begin
                    cnt--;
                end
            end
            if (ph == 1) begin
                chk("dmem_req_held", 32'(dmem_req), 32'd1);
                chk("dmem_we", 32'(dmem_we), 32'(cur.we));
                chk("dmem_addr", dmem_addr, cur.addr);
                chk("ex_ready_busy", 32'(ex_ready), 32'd0);
                if (cur.we) begin
                    chk("dmem_wdata", dmem_wdata, cur.wdata);
                    chk("dmem_be", 32'(dmem_be), 32'(cur.be));
                end
                if (cnt == 0) begin
                    dmem_gnt = 1'b1;
                    ph = cur.we ? 0 : 2;
                    cnt = cur.rdly;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin : stim
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_misalign", 32'(wb_misalign), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(2'd0, 2'd2, 0, 32'h1234, 0, 5'd5, 1, 0, 0, 0);
        issue(2'd0, 2'd0, 0, 32'hDEAD_BEEF, 0, 5'd6, 0, 0, 0, 0);
        issue(2'd3, 2'd1, 0, 32'h0000_0101, 0, 5'd7, 1, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        n = wb_cycs.size();
        if (n < 3) chk("b2b_count", 32'(n), 32'd3);
        else chk("b2b_spacing", 32'(wb_cycs[n-1] - wb_cycs[n-3]), 32'd2);
        @(posedge clk);
        #1;

        issue(2'd2, 2'd0, 0, 32'h103, 32'hAABB_CCDD, 5'd1, 1, 0, 3, 0);
        issue(2'd1, 2'd1, 0, 32'h202, 0, 5'd8, 1, 32'h8001_7FFF, 0, 1);
        issue(2'd1, 2'd1, 1, 32'h202, 0, 5'd9, 1, 32'h8001_7FFF, 1, 1);
        issue(2'd1, 2'd0, 0, 32'h201, 0, 5'd10, 1, 32'h0000_F000, 0, 0);
        issue(2'd1, 2'd2, 0, 32'h300, 0, 5'd11, 1, 32'h1234_5678, 2, 0);
        issue(2'd2, 2'd2, 0, 32'h402, 32'h1111_2222, 5'd12, 1, 0, 0, 0);
        issue(2'd0, 2'd0, 0, 32'h55, 0, 5'd13, 1, 0, 0, 0);

        repeat (6) @(posedge clk);
        #1;
        issue(2'd1, 2'd2, 0, 32'h500, 0, 5'd7, 1, 32'hCAFE_F00D, 0, 8);
        repeat (3) @(posedge clk);
        #2;
        wbq.delete();
        rst_n = 1'b0;
        #1;
        chk("arst_dmem_req", 32'(dmem_req), 32'd0);
        chk("arst_wb_valid", 32'(wb_valid), 32'd0);
        chk("arst_wb_rd", 32'(wb_rd), 32'd0);
        chk("arst_wb_data", wb_data, 32'd0);
        chk("arst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("arst_ex_ready", 32'(ex_ready), 32'd1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ex_ready", 32'(ex_ready), 32'd1);
        issue(2'd0, 2'd0, 0, 32'h77, 0, 5'd3, 1, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
            issue(2'($urandom_range(3)), 2'($urandom_range(3)),
                  1'($urandom_range(1)), $urandom, $urandom,
                  5'($urandom_range(31)), 1'($urandom_range(1)),
                  $urandom, $urandom_range(3), $urandom_range(3));
        end

        n = 0;
        while ((wbq.size() != 0 || memq.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
        chk("drain_wbq", 32'(wbq.size()), 32'd0);
        chk("drain_memq", 32'(memq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute-stage ALU.
- Consumes the ALU result either as a pass-through writeback value or as the effective address of a load/store.
- Runs the data-memory request/grant/response handshake, with byte-lane steering, sign/zero extension and misalignment detection.
- Presents one registered result per instruction to writeback.
- Stalls execute through ex_ready while a memory transaction is outstanding.

Parameters:
- ADDR_WIDTH, 32, width of dmem_addr. Uses the low ADDR_WIDTH bits of alu_res.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  execute presents an instruction this cycle.
- ex_ready  out  1  stage accepts; transfer when ex_valid && ex_ready.
- alu_res  in  32  ALU output: result or effective byte address.
- rs2_data  in  32  store data.
- rd_addr  in  5  destination register.
- reg_write  in  1  instruction writes rd.
- mem_op  in  2  0=NONE, 1=LOAD, 2=STORE, 3=reserved (treated as NONE).
- mem_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word).
- mem_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
- dmem_req  out  1  memory request; held until dmem_gnt.
- dmem_we  out  1  1=store.
- dmem_addr  out  ADDR_WIDTH  word-aligned address ([1:0]=0).
- dmem_wdata  out  32  lane-aligned store data.
- dmem_be  out  4  byte enables; meaningful only for stores.
- dmem_gnt  in  1  memory accepts the request this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  load data word.
- wb_valid  out  1  single-cycle pulse; writeback always accepts.
- wb_rd  out  5  destination register.
- wb_data  out  32  writeback value.
- wb_reg_write  out  1  write enable for the register file.
- wb_misalign  out  1  misaligned access flagged, qualified by wb_valid.

Behaviour:
- Reset: state=IDLE. All outputs except ex_ready are 0: dmem_*, wb_*, wb_misalign. ex_ready=1.
- Reset assertion mid-transaction abandons the transaction immediately:
  - dmem_req drops asynchronously.
  - No wb_valid is produced for that instruction.
- States:
  - IDLE: ex_ready=1.
  - REQ: waiting for dmem_gnt.
  - RESP: waiting for dmem_rvalid.
- ex_ready = (state==IDLE), combinational from state only.
- All dmem_* and wb_* outputs are registered.
- IDLE, transfer of a NONE op: next cycle wb_valid=1, wb_data=alu_res, wb_rd=rd_addr, wb_reg_write=reg_write. Stay in IDLE. Latency is 1 and back-to-back transfers are allowed.
- Misalignment rule: half with addr[0]=1, or word with addr[1:0]!=0.
- IDLE, transfer of a misaligned LOAD/STORE:
  - No dmem_req is issued.
  - Next cycle wb_valid=1, wb_misalign=1, wb_reg_write=0, wb_data=alu_res (faulting address).
  - Stay in IDLE.
- IDLE, transfer of an aligned LOAD/STORE:
  - Capture addr[1:0], size, unsigned, rd and reg_write.
  - Drive dmem_req=1, dmem_we=(STORE), dmem_addr={alu_res[ADDR_WIDTH-1:2],2'b00}. These become visible the next cycle.
  - Go to REQ.
- REQ: dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be are held stable until dmem_gnt=1.
  - On the gnt cycle with a store: dmem_req drops next cycle, wb_valid pulses next cycle with wb_reg_write=0, go to IDLE.
  - On the gnt cycle with a load: dmem_req drops next cycle, go to RESP.
- RESP: dmem_rvalid is not sampled in REQ; memory guarantees rvalid no earlier than the cycle after gnt.
  - On rvalid: lane = dmem_rdata >> (addr[1:0]*8).
  - byte: ext(lane[7:0]). half: ext(lane[15:0]). word: dmem_rdata.
  - ext is zero-extension if mem_unsigned, else sign-extension.
  - Next cycle wb_valid=1, wb_data=extended value, wb_reg_write=captured reg_write. Go to IDLE.
- Store steering:
  - byte: wdata = {4{rs2[7:0]}}, be = 4'b0001 << addr[1:0].
  - half: wdata = {2{rs2[15:0]}}, be = 4'b0011 << addr[1:0].
  - word: wdata = rs2, be = 4'b1111.
- Minimum latency from transfer cycle N:
  - NONE or misaligned: wb_valid at N+1.
  - STORE: req at N+1, gnt at N+1 earliest, wb_valid at N+2, ex_ready at N+2.
  - LOAD: rvalid at N+2 earliest, wb_valid at N+3.
- wb_valid is a pulse; wb_* fields hold their last value when wb_valid=0.
- wb_misalign clears on the next non-faulting wb_valid.

Test Plan:
- NONE op, alu_res=0x0000_1234, rd=5, reg_write=1 -> wb_valid next cycle, wb_data=0x1234, wb_rd=5, wb_reg_write=1. 3 back-to-back ops produce 3 consecutive wb_valid pulses.
- STORE byte, alu_res=0x103, rs2=0xAABBCCDD, gnt held low 3 cycles -> dmem_addr=0x100, be=4'b1000, wdata=0xDDDDDDDD stable for 4 cycles. ex_ready=0 throughout. wb_valid with reg_write=0 the cycle after gnt.
- LOAD half signed, alu_res=0x202, rdata=0x8001_7FFF, rvalid 2 cycles after gnt -> wb_data=0xFFFF8001. The same access with mem_unsigned=1 gives 0x00008001.
- LOAD byte signed at addr[1:0]=1, rdata=0x0000_F000 -> wb_data=0xFFFFFFF0. LOAD word at 0x300, rdata=0x12345678 -> wb_data=0x12345678.
- Misaligned word STORE at alu_res=0x402 -> dmem_req never asserts. Next cycle wb_valid=1, wb_misalign=1, wb_data=0x402, wb_reg_write=0.
- rst_n asserted while in RESP -> dmem_req=0 and all wb_* outputs 0 immediately; no wb_valid. After release, ex_ready=1 and a NONE op completes normally.
